// File: rtl/mc_control_unit_if.sv
// Control interface between the instruction register / ALU flags and the
// multicycle datapath control inputs.
interface mc_control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;

    logic [1:0] ALUSrcAControl;
    logic [1:0] ALUSrcBControl;
    logic [2:0] ALUOp;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       ABWrite;
    logic       ALUOutWrite;
    logic       MDRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       EPCWrite;
    logic       CauseWrite;
    logic       Cause;
    logic [3:0] state_out;

    // Control unit side: consumes IR fields and flags, drives datapath controls
    modport master (
        input  opcode, funct, zero, overflow,
        output ALUSrcAControl, ALUSrcBControl, ALUOp, PCWrite, PCSource,
               IorD, MemWrite, IRWrite, ABWrite, ALUOutWrite, MDRWrite,
               RegWrite, RegDst, MemToReg, EPCWrite, CauseWrite, Cause,
               state_out
    );

    // Datapath side
    modport slave (
        output opcode, funct, zero, overflow,
        input  ALUSrcAControl, ALUSrcBControl, ALUOp, PCWrite, PCSource,
               IorD, MemWrite, IRWrite, ABWrite, ALUOutWrite, MDRWrite,
               RegWrite, RegDst, MemToReg, EPCWrite, CauseWrite, Cause,
               state_out
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: sequences fetch, decode, execute, memory access,
// write-back and exception entry for add/sub/and/addi/lw/sw/addm/beq/j.
module mc_control_unit #(
    parameter int unsigned MEM_LAT  = 1,
    parameter logic [5:0]  OPC_ADDM = 6'h01
) (
    input  logic               clk,
    input  logic               reset_n,
    mc_control_unit_if.master  bus
);

    localparam int unsigned CNT_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    typedef enum logic [3:0] {
        RST     = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        EXEC_R  = 4'd3,
        RWB     = 4'd4,
        ADDR    = 4'd5,
        MEM_RD  = 4'd6,
        LWB     = 4'd7,
        ADDM_EX = 4'd8,
        IWB     = 4'd9,
        MEM_WR  = 4'd10,
        BRANCH  = 4'd11,
        JUMP    = 4'd12,
        EXC     = 4'd13
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               cause_q, cause_d;
    logic               done;
    logic               cnt_load;

    assign done     = (cnt_q == '0);
    assign cnt_load = (state_d != state_q) && (state_d == FETCH || state_d == MEM_RD);

    // State, memory wait counter and exception cause latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST;
            cnt_q   <= '0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_load)
                cnt_q <= CNT_W'(MEM_LAT);
            else if (!done)
                cnt_q <= cnt_q - CNT_W'(1);
            if (state_d == EXC && state_q != EXC)
                cause_q <= cause_d;
        end
    end

    // Next-state logic and exception cause selection
    always_comb begin
        state_d = state_q;
        cause_d = 1'b0;
        case (state_q)
            RST:     state_d = FETCH;
            FETCH:   if (done) state_d = DECODE;
            DECODE: begin
                if (bus.opcode == OP_RTYPE) begin
                    if (bus.funct == FN_ADD || bus.funct == FN_SUB || bus.funct == FN_AND) begin
                        state_d = EXEC_R;
                    end else begin
                        state_d = EXC;
                        cause_d = 1'b1;
                    end
                end else if (bus.opcode == OP_ADDI || bus.opcode == OP_LW ||
                             bus.opcode == OP_SW   || bus.opcode == OPC_ADDM) begin
                    state_d = ADDR;
                end else if (bus.opcode == OP_BEQ) begin
                    state_d = BRANCH;
                end else if (bus.opcode == OP_J) begin
                    state_d = JUMP;
                end else begin
                    state_d = EXC;
                    cause_d = 1'b1;
                end
            end
            // and never traps; add/sub trap on signed overflow
            EXEC_R:  state_d = (bus.funct != FN_AND && bus.overflow) ? EXC : RWB;
            ADDR: begin
                if (bus.opcode == OP_ADDI)
                    state_d = bus.overflow ? EXC : IWB;
                else if (bus.opcode == OP_SW)
                    state_d = MEM_WR;
                else
                    state_d = MEM_RD;
            end
            MEM_RD:  if (done) state_d = (bus.opcode == OP_LW) ? LWB : ADDM_EX;
            ADDM_EX: state_d = bus.overflow ? EXC : IWB;
            RWB, LWB, IWB, MEM_WR, BRANCH, JUMP, EXC: state_d = FETCH;
            default: state_d = RST;
        endcase
    end

    // Moore control decode (PCWrite in BRANCH follows the zero flag)
    always_comb begin
        bus.ALUSrcAControl = 2'b00;
        bus.ALUSrcBControl = 2'b00;
        bus.ALUOp          = 3'b000;
        bus.PCWrite        = 1'b0;
        bus.PCSource       = 2'b00;
        bus.IorD           = 1'b0;
        bus.MemWrite       = 1'b0;
        bus.IRWrite        = 1'b0;
        bus.ABWrite        = 1'b0;
        bus.ALUOutWrite    = 1'b0;
        bus.MDRWrite       = 1'b0;
        bus.RegWrite       = 1'b0;
        bus.RegDst         = 1'b0;
        bus.MemToReg       = 1'b0;
        bus.EPCWrite       = 1'b0;
        bus.CauseWrite     = 1'b0;
        bus.Cause          = 1'b0;
        bus.state_out      = state_q;
        case (state_q)
            FETCH: begin
                if (done) begin
                    bus.IRWrite        = 1'b1;
                    bus.ALUSrcAControl = 2'b10;
                    bus.ALUSrcBControl = 2'b01;
                    bus.ALUOp          = ALU_ADD;
                    bus.PCWrite        = 1'b1;
                end
            end
            DECODE: begin
                bus.ABWrite        = 1'b1;
                bus.ALUSrcAControl = 2'b10;
                bus.ALUSrcBControl = 2'b11;
                bus.ALUOp          = ALU_ADD;
                bus.ALUOutWrite    = 1'b1;
            end
            EXEC_R: begin
                bus.ALUSrcAControl = 2'b01;
                bus.ALUOutWrite    = 1'b1;
                if (bus.funct == FN_SUB)
                    bus.ALUOp = ALU_SUB;
                else if (bus.funct == FN_AND)
                    bus.ALUOp = ALU_AND;
                else
                    bus.ALUOp = ALU_ADD;
            end
            RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            ADDR: begin
                bus.ALUSrcAControl = 2'b01;
                bus.ALUSrcBControl = 2'b10;
                bus.ALUOp          = ALU_ADD;
                bus.ALUOutWrite    = 1'b1;
            end
            MEM_RD: begin
                bus.IorD     = 1'b1;
                bus.MDRWrite = done;
            end
            LWB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = 1'b1;
            end
            ADDM_EX: begin
                bus.ALUSrcAControl = 2'b11;
                bus.ALUOp          = ALU_ADD;
                bus.ALUOutWrite    = 1'b1;
            end
            IWB:     bus.RegWrite = 1'b1;
            MEM_WR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcAControl = 2'b01;
                bus.ALUOp          = ALU_SUB;
                bus.PCSource       = 2'b01;
                bus.PCWrite        = bus.zero;
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            // EPC gets PC-4, i.e. the address of the faulting instruction
            EXC: begin
                bus.ALUSrcAControl = 2'b10;
                bus.ALUSrcBControl = 2'b01;
                bus.ALUOp          = ALU_SUB;
                bus.EPCWrite       = 1'b1;
                bus.CauseWrite     = 1'b1;
                bus.Cause          = cause_q;
                bus.PCWrite        = 1'b1;
                bus.PCSource       = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit with MEM_LAT=1.
module tb_mc_control_unit;

    typedef struct packed {
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memw;
        logic       irw;
        logic       abw;
        logic       aluoutw;
        logic       mdrw;
        logic       regw;
        logic       regdst;
        logic       memtoreg;
        logic       epcw;
        logic       causew;
        logic       cause;
    } ctl_t;

    localparam logic [3:0] S_RST = 4'd0,  S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                           S_RWB = 4'd4,  S_ADDR  = 4'd5, S_MEM_RD = 4'd6, S_LWB    = 4'd7,
                           S_ADDM_EX = 4'd8, S_IWB = 4'd9, S_MEM_WR = 4'd10, S_BRANCH = 4'd11,
                           S_JUMP = 4'd12, S_EXC = 4'd13;

    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    mc_control_unit_if bus();

    mc_control_unit #(.MEM_LAT(1), .OPC_ADDM(6'h01)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t get_obs();
        ctl_t o;
        o.srca = bus.ALUSrcAControl;  o.srcb = bus.ALUSrcBControl; o.aluop = bus.ALUOp;
        o.pcw = bus.PCWrite;          o.pcsrc = bus.PCSource;      o.iord = bus.IorD;
        o.memw = bus.MemWrite;        o.irw = bus.IRWrite;         o.abw = bus.ABWrite;
        o.aluoutw = bus.ALUOutWrite;  o.mdrw = bus.MDRWrite;       o.regw = bus.RegWrite;
        o.regdst = bus.RegDst;        o.memtoreg = bus.MemToReg;   o.epcw = bus.EPCWrite;
        o.causew = bus.CauseWrite;    o.cause = bus.Cause;
        return o;
    endfunction

    // Expected control words, written out from the per-state control table
    function automatic ctl_t w_zero();
        ctl_t e; e = '0; return e;
    endfunction
    function automatic ctl_t w_fdone();
        ctl_t e; e = '0; e.irw = 1'b1; e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 3'b001; e.pcw = 1'b1;
        return e;
    endfunction
    function automatic ctl_t w_dec();
        ctl_t e; e = '0; e.abw = 1'b1; e.srca = 2'b10; e.srcb = 2'b11; e.aluop = 3'b001; e.aluoutw = 1'b1;
        return e;
    endfunction
    function automatic ctl_t w_exec(input logic [2:0] op);
        ctl_t e; e = '0; e.srca = 2'b01; e.aluop = op; e.aluoutw = 1'b1;
        return e;
    endfunction
    function automatic ctl_t w_rwb();
        ctl_t e; e = '0; e.regw = 1'b1; e.regdst = 1'b1; return e;
    endfunction
    function automatic ctl_t w_addr();
        ctl_t e; e = '0; e.srca = 2'b01; e.srcb = 2'b10; e.aluop = 3'b001; e.aluoutw = 1'b1;
        return e;
    endfunction
    function automatic ctl_t w_memrd(input logic last);
        ctl_t e; e = '0; e.iord = 1'b1; e.mdrw = last; return e;
    endfunction
    function automatic ctl_t w_lwb();
        ctl_t e; e = '0; e.regw = 1'b1; e.memtoreg = 1'b1; return e;
    endfunction
    function automatic ctl_t w_addmex();
        ctl_t e; e = '0; e.srca = 2'b11; e.aluop = 3'b001; e.aluoutw = 1'b1; return e;
    endfunction
    function automatic ctl_t w_iwb();
        ctl_t e; e = '0; e.regw = 1'b1; return e;
    endfunction
    function automatic ctl_t w_memwr();
        ctl_t e; e = '0; e.iord = 1'b1; e.memw = 1'b1; return e;
    endfunction
    function automatic ctl_t w_br(input logic taken);
        ctl_t e; e = '0; e.srca = 2'b01; e.aluop = 3'b010; e.pcsrc = 2'b01; e.pcw = taken;
        return e;
    endfunction
    function automatic ctl_t w_jump();
        ctl_t e; e = '0; e.pcw = 1'b1; e.pcsrc = 2'b10; return e;
    endfunction
    function automatic ctl_t w_exc(input logic c);
        ctl_t e; e = '0; e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 3'b010; e.epcw = 1'b1;
        e.causew = 1'b1; e.cause = c; e.pcw = 1'b1; e.pcsrc = 2'b11;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] st, input ctl_t e);
        chk({tag, "/state"}, 32'(bus.state_out), 32'(st));
        chk({tag, "/ctl"}, 32'(get_obs()), 32'(e));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input string tag, input logic [3:0] st, input ctl_t e);
        next_cycle();
        chk_state(tag, st, e);
    endtask

    // Linear directed sequence; each instruction starts in the FETCH wait cycle
    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n      = 1'b1;
        bus.opcode   = 6'h00;
        bus.funct    = 6'h00;
        bus.zero     = 1'b0;
        bus.overflow = 1'b0;
        #1 reset_n = 1'b0;
        #1 chk_state("reset", S_RST, w_zero());
        next_cycle();
        chk_state("reset_hold", S_RST, w_zero());
        reset_n = 1'b1;
        #1 chk_state("release", S_RST, w_zero());
        step("fetch_wait0", S_FETCH, w_zero());

        // add
        bus.opcode = 6'h00; bus.funct = 6'h20;
        step("add_fetch", S_FETCH, w_fdone());
        step("add_dec", S_DECODE, w_dec());
        step("add_exec", S_EXEC_R, w_exec(3'b001));
        step("add_wb", S_RWB, w_rwb());
        step("add_next", S_FETCH, w_zero());

        // addm
        bus.opcode = 6'h01;
        step("addm_fetch", S_FETCH, w_fdone());
        step("addm_dec", S_DECODE, w_dec());
        step("addm_addr", S_ADDR, w_addr());
        step("addm_rd1", S_MEM_RD, w_memrd(1'b0));
        step("addm_rd2", S_MEM_RD, w_memrd(1'b1));
        step("addm_ex", S_ADDM_EX, w_addmex());
        step("addm_wb", S_IWB, w_iwb());
        step("addm_next", S_FETCH, w_zero());

        // beq taken / not taken
        bus.opcode = 6'h04; bus.zero = 1'b1;
        step("beq1_fetch", S_FETCH, w_fdone());
        step("beq1_dec", S_DECODE, w_dec());
        step("beq1_br", S_BRANCH, w_br(1'b1));
        step("beq1_next", S_FETCH, w_zero());
        bus.zero = 1'b0;
        step("beq0_fetch", S_FETCH, w_fdone());
        step("beq0_dec", S_DECODE, w_dec());
        step("beq0_br", S_BRANCH, w_br(1'b0));
        step("beq0_next", S_FETCH, w_zero());

        // illegal opcode
        bus.opcode = 6'h3F;
        step("ill_fetch", S_FETCH, w_fdone());
        step("ill_dec", S_DECODE, w_dec());
        step("ill_exc", S_EXC, w_exc(1'b1));
        step("ill_next", S_FETCH, w_zero());

        // addi overflow
        bus.opcode = 6'h08; bus.overflow = 1'b1;
        step("addiov_fetch", S_FETCH, w_fdone());
        step("addiov_dec", S_DECODE, w_dec());
        step("addiov_addr", S_ADDR, w_addr());
        step("addiov_exc", S_EXC, w_exc(1'b0));
        step("addiov_next", S_FETCH, w_zero());
        bus.overflow = 1'b0;

        // illegal funct
        bus.opcode = 6'h00; bus.funct = 6'h2A;
        step("slt_fetch", S_FETCH, w_fdone());
        step("slt_dec", S_DECODE, w_dec());
        step("slt_exc", S_EXC, w_exc(1'b1));
        step("slt_next", S_FETCH, w_zero());

        // sw
        bus.opcode = 6'h2B;
        step("sw_fetch", S_FETCH, w_fdone());
        step("sw_dec", S_DECODE, w_dec());
        step("sw_addr", S_ADDR, w_addr());
        step("sw_wr", S_MEM_WR, w_memwr());
        step("sw_next", S_FETCH, w_zero());

        // sub with overflow traps
        bus.opcode = 6'h00; bus.funct = 6'h22; bus.overflow = 1'b1;
        step("subov_fetch", S_FETCH, w_fdone());
        step("subov_dec", S_DECODE, w_dec());
        step("subov_exec", S_EXEC_R, w_exec(3'b010));
        step("subov_exc", S_EXC, w_exc(1'b0));
        step("subov_next", S_FETCH, w_zero());

        // and ignores overflow
        bus.funct = 6'h24;
        step("andov_fetch", S_FETCH, w_fdone());
        step("andov_dec", S_DECODE, w_dec());
        step("andov_exec", S_EXEC_R, w_exec(3'b011));
        step("andov_wb", S_RWB, w_rwb());
        step("andov_next", S_FETCH, w_zero());
        bus.overflow = 1'b0;

        // j
        bus.opcode = 6'h02;
        step("j_fetch", S_FETCH, w_fdone());
        step("j_dec", S_DECODE, w_dec());
        step("j_jump", S_JUMP, w_jump());
        step("j_next", S_FETCH, w_zero());

        // lw
        bus.opcode = 6'h23;
        step("lw_fetch", S_FETCH, w_fdone());
        step("lw_dec", S_DECODE, w_dec());
        step("lw_addr", S_ADDR, w_addr());
        step("lw_rd1", S_MEM_RD, w_memrd(1'b0));
        step("lw_rd2", S_MEM_RD, w_memrd(1'b1));
        step("lw_wb", S_LWB, w_lwb());
        step("lw_next", S_FETCH, w_zero());

        // lw interrupted by reset in MEM_RD
        step("lwr_fetch", S_FETCH, w_fdone());
        step("lwr_dec", S_DECODE, w_dec());
        step("lwr_addr", S_ADDR, w_addr());
        step("lwr_rd1", S_MEM_RD, w_memrd(1'b0));
        #1 reset_n = 1'b0;
        #1 chk_state("midrst", S_RST, w_zero());
        next_cycle();
        chk_state("midrst_hold", S_RST, w_zero());
        reset_n = 1'b1;
        #1 chk_state("midrst_release", S_RST, w_zero());
        step("midrst_fetch_wait", S_FETCH, w_zero());
        step("midrst_fetch_done", S_FETCH, w_fdone());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
